// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 4-bit ALU front end.
//   ALU_W          : operand width (4)
//   alu_op_t       : 2-bit opcode encoding (AND, XOR, SUB, MUL)
//   loader_state_t : operand loader FSM states, encoding doubles as LED code
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W = 4;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_XOR = 2'b01,
        OP_SUB = 2'b10,
        OP_MUL = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        WAIT_A  = 2'b00,
        WAIT_B  = 2'b01,
        WAIT_OP = 2'b10,
        READY   = 2'b11
    } loader_state_t;

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Debounces one raw push-button and emits a single-cycle pulse on the
// accepted 0->1 transition of the debounced level.
// Optional macro ALU_LOADER_SYNC_EN: when defined, the raw button first
// passes through a 2-flop synchronizer.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   btn   : raw button, active-high
//   rise  : combinational pulse, high for the edge on which the debounced
//           level goes 0->1 (consumed by logic clocked on that same edge)
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sample;
    logic          db;
    logic [CW-1:0] cnt;
    logic          accept;

`ifdef ALU_LOADER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn};
        end
    end

    assign sample = sync_q[1];
`else
    // Input is assumed already synchronous to clk.
    assign sample = btn;
`endif

    // The new level is accepted on the sample that would be the
    // DEBOUNCE_CYCLES-th consecutive one differing from db.
    assign accept = (sample != db) && (cnt == CNT_MAX);
    assign rise   = accept && sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db  <= 1'b0;
            cnt <= '0;
        end else if (sample == db) begin
            cnt <= '0;
        end else if (accept) begin
            db  <= sample;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_operand_loader.sv
// ---------------------------------------------------------------------------
// alu_operand_loader
// Time-multiplexes one 4-bit switch bank into operand A, operand B and the
// 2-bit opcode of the ALU using debounced load presses. A debounced clear
// press aborts any sequence and zeroes the operand set.
// Optional macro ALU_LOADER_SYNC_EN: adds a 2-flop synchronizer in front of
// each button debouncer.
// Ports:
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   sw[3:0]   : switch bank (quasi-static, sampled directly)
//   btn_load  : raw load button, active-high
//   btn_clear : raw clear button, active-high
//   A[3:0]    : captured operand A
//   B[3:0]    : captured operand B
//   Op[1:0]   : captured opcode (00 AND, 01 XOR, 10 SUB, 11 MUL)
//   op_valid  : level, high while A/B/Op form a complete operand set; there
//               is no back-pressure, the ALU simply uses the set while high
//   stage[1:0]: current FSM state (00 WAIT_A, 01 WAIT_B, 10 WAIT_OP, 11 READY)
// ---------------------------------------------------------------------------
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ALU_W-1:0] sw,
    input  logic             btn_load,
    input  logic             btn_clear,
    output logic [ALU_W-1:0] A,
    output logic [ALU_W-1:0] B,
    output logic [1:0]       Op,
    output logic             op_valid,
    output logic [1:0]       stage
);

    logic          load_ev;
    logic          clear_ev;
    loader_state_t state;
    alu_op_t       op_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_load),
        .rise  (load_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_clear),
        .rise  (clear_ev)
    );

    // Clear has priority: a coincident load is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WAIT_A;
            A        <= '0;
            B        <= '0;
            op_q     <= OP_AND;
            op_valid <= 1'b0;
        end else if (clear_ev) begin
            state    <= WAIT_A;
            A        <= '0;
            B        <= '0;
            op_q     <= OP_AND;
            op_valid <= 1'b0;
        end else if (load_ev) begin
            case (state)
                WAIT_A: begin
                    A     <= sw;
                    state <= WAIT_B;
                end
                WAIT_B: begin
                    B     <= sw;
                    state <= WAIT_OP;
                end
                WAIT_OP: begin
                    op_q     <= alu_op_t'(sw[1:0]);
                    op_valid <= 1'b1;
                    state    <= READY;
                end
                READY: begin
                    // New sequence; B and Op remain until overwritten.
                    A        <= sw;
                    op_valid <= 1'b0;
                    state    <= WAIT_B;
                end
                default: state <= WAIT_A;
            endcase
        end
    end

    assign Op    = op_q;
    assign stage = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_loader
// Directed bench for alu_operand_loader with DEBOUNCE_CYCLES = 4. A small
// reference model computes the expected operand set for each press; a
// negedge monitor pops the expected value and capture edge whenever the
// DUT outputs change.
// ---------------------------------------------------------------------------
module tb_alu_operand_loader;

    localparam int D = 4;
`ifdef ALU_LOADER_SYNC_EN
    localparam int CAP_OFS = D + 1;
`else
    localparam int CAP_OFS = D - 1;
`endif
    localparam int W = 13;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw = 4'h0;
    logic       btn_load = 1'b0;
    logic       btn_clear = 1'b0;
    logic [3:0] A;
    logic [3:0] B;
    logic [1:0] Op;
    logic       op_valid;
    logic [1:0] stage;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt = 0;

    logic [W-1:0] exp_q[$];
    int           exp_edge_q[$];

    // Reference model state
    logic [1:0] m_stage = 2'b00;
    logic [3:0] m_a = 4'h0;
    logic [3:0] m_b = 4'h0;
    logic [1:0] m_op = 2'b00;
    logic       m_v = 1'b0;

    alu_operand_loader #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .btn_load  (btn_load),
        .btn_clear (btn_clear),
        .A         (A),
        .B         (B),
        .Op        (Op),
        .op_valid  (op_valid),
        .stage     (stage)
    );

    // ---------------- clock / edge counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    // ---------------- model ----------------
    function automatic logic [W-1:0] model_pack();
        return {m_stage, m_a, m_b, m_op, m_v};
    endfunction

    task automatic model_clear();
        m_stage = 2'b00; m_a = 4'h0; m_b = 4'h0; m_op = 2'b00; m_v = 1'b0;
    endtask

    task automatic model_load(input logic [3:0] s);
        case (m_stage)
            2'b00: begin m_a = s; m_stage = 2'b01; end
            2'b01: begin m_b = s; m_stage = 2'b10; end
            2'b10: begin m_op = s[1:0]; m_v = 1'b1; m_stage = 2'b11; end
            default: begin m_a = s; m_v = 1'b0; m_stage = 2'b01; end
        endcase
    endtask

    // ---------------- checks ----------------
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [W-1:0] last;
    always @(negedge clk) begin
        logic [W-1:0] cur;
        logic [W-1:0] e;
        int           ee;
        cur = {stage, A, B, Op, op_valid};
        if (!rst_n) begin
            last = cur;
        end else if (cur !== last) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL unexpected_change observed=%h expected=no_change", cur);
            end else begin
                e  = exp_q.pop_front();
                ee = exp_edge_q.pop_front();
                check("capture_value", cur, e);
                n_tests++;
                assert (edge_cnt === ee) else begin
                    n_fail++;
                    $error("FAIL capture_edge observed=%0d expected=%0d", edge_cnt, ee);
                end
            end
            last = cur;
        end
    end

    // ---------------- driver tasks ----------------
    // Press (and hold) buttons; a load/clear event is expected CAP_OFS edges
    // after the first edge that sees the button high.
    task automatic press(input logic ld, input logic clr, input logic [3:0] s, input int hold);
        int k;
        @(posedge clk); #1;
        sw = s;
        btn_load = ld;
        btn_clear = clr;
        k = edge_cnt + 1;
        if (clr) model_clear();
        else if (ld) model_load(s);
        exp_q.push_back(model_pack());
        exp_edge_q.push_back(k + CAP_OFS);
        repeat (hold) @(posedge clk);
        #1;
        btn_load = 1'b0;
        btn_clear = 1'b0;
        repeat (D + 6) @(posedge clk);
    endtask

    task automatic glitch(input int n);
        @(posedge clk); #1;
        btn_load = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        btn_load = 1'b0;
        repeat (D) @(posedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_init", {stage, A, B, Op, op_valid}, '0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Full load sequence
        press(1'b1, 1'b0, 4'b1100, 8);
        press(1'b1, 1'b0, 4'b1010, 8);
        press(1'b1, 1'b0, 4'b0000, 8);
        check("full_A", {9'd0, A}, {9'd0, 4'b1100});
        check("full_B", {9'd0, B}, {9'd0, 4'b1010});
        check("full_Op", {11'd0, Op}, {11'd0, 2'b00});
        check("full_valid_stage", {10'd0, op_valid, stage}, {10'd0, 1'b1, 2'b11});

        // Asynchronous reset mid-cycle
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", {stage, A, B, Op, op_valid}, '0);
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Bounce rejection (monitor flags any change)
        glitch(1);
        glitch(2);
        glitch(3);
        repeat (D + 4) @(posedge clk);
        #1;
        check("bounce_stage", {11'd0, stage}, {11'd0, 2'b00});
        check("bounce_A", {9'd0, A}, 13'd0);

        // Held 10 cycles: exactly one capture, which is A after reset
        press(1'b1, 1'b0, 4'b0101, 10);
        check("hold_stage", {11'd0, stage}, {11'd0, 2'b01});
        press(1'b1, 1'b0, 4'b0011, 8);
        press(1'b1, 1'b0, 4'b0010, 8);
        check("ready_set", {stage, A, B, Op, op_valid}, {2'b11, 4'b0101, 4'b0011, 2'b10, 1'b1});

        // Restart from READY
        press(1'b1, 1'b0, 4'b0010, 8);
        check("restart", {stage, A, B, Op, op_valid}, {2'b01, 4'b0010, 4'b0011, 2'b10, 1'b0});

        // Clear and load coincide in WAIT_OP
        press(1'b1, 1'b0, 4'b0110, 8);
        check("pre_clear_stage", {11'd0, stage}, {11'd0, 2'b10});
        press(1'b1, 1'b1, 4'b1111, 8);
        check("clear_wins", {stage, A, B, Op, op_valid}, '0);

        // Opcode masking
        press(1'b1, 1'b0, 4'b0100, 8);
        press(1'b1, 1'b0, 4'b0111, 8);
        press(1'b1, 1'b0, 4'b1111, 8);
        check("op_mask", {stage, A, B, Op, op_valid}, {2'b11, 4'b0100, 4'b0111, 2'b11, 1'b1});

        repeat (4) @(posedge clk);
        n_tests++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL missing_captures observed=%0d expected=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
